// File: rtl/stage_mem_access.sv
// Memory-access stage: registers pass-through results and runs load/store bus transactions
// with lane steering, load extension, misalignment detection and a bus timeout.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | ready for a new instruction from EX
// ST_ACCESS | bus request outstanding, upstream stalled via o_hazard
module stage_mem_access #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_valid,
    input  logic [DATA_WIDTH-1:0] i_result,
    input  logic [DATA_WIDTH-1:0] i_dataB,
    input  logic                  i_memRead,
    input  logic                  i_memWrite,
    input  logic [1:0]            i_access,
    input  logic                  i_unsigned,
    output logic                  o_hazard,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_result,
    output logic                  o_misaligned,
    output logic                  o_busError,
    output logic                  o_memReq,
    output logic                  o_memWrEnable,
    output logic [ADDR_WIDTH-1:0] o_memAddr,
    output logic [3:0]            o_memByteEnable,
    output logic [DATA_WIDTH-1:0] o_memWrData,
    input  logic                  i_memAck,
    input  logic [DATA_WIDTH-1:0] i_memRdData
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic {ST_IDLE, ST_ACCESS} state_t;

    state_t                state_q, state_d;
    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic                  misaligned_q, misaligned_d;
    logic                  bus_error_q, bus_error_d;
    logic                  mem_req_q, mem_req_d;
    logic                  wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [3:0]            be_q, be_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic [1:0]            size_q, size_d;
    logic                  unsigned_q, unsigned_d;
    logic [1:0]            lane_q, lane_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    logic                  illegal;
    logic [3:0]            be_calc;
    logic [DATA_WIDTH-1:0] wr_steer;
    logic [7:0]            rd_byte;
    logic [15:0]           rd_half;
    logic [DATA_WIDTH-1:0] load_data;
    logic                  timeout_hit;

    always_comb begin
        illegal = (i_access == 2'b11) || (i_memRead && i_memWrite) ||
                  ((i_access == 2'b01) && i_result[0]) ||
                  ((i_access == 2'b10) && (i_result[1:0] != 2'b00));
        case (i_access)
            2'b00: begin
                be_calc  = 4'b0001 << i_result[1:0];
                wr_steer = {4{i_dataB[7:0]}};
            end
            2'b01: begin
                be_calc  = 4'b0011 << i_result[1:0];
                wr_steer = {2{i_dataB[15:0]}};
            end
            default: begin
                be_calc  = 4'b1111;
                wr_steer = i_dataB;
            end
        endcase
    end

    // Lane select uses the registered offset; read data arrives only with the ack.
    always_comb begin
        case (lane_q)
            2'd0:    rd_byte = i_memRdData[7:0];
            2'd1:    rd_byte = i_memRdData[15:8];
            2'd2:    rd_byte = i_memRdData[23:16];
            default: rd_byte = i_memRdData[31:24];
        endcase
        rd_half = lane_q[1] ? i_memRdData[31:16] : i_memRdData[15:0];
        case (size_q)
            2'b00:   load_data = {{(DATA_WIDTH-8){rd_byte[7] & ~unsigned_q}}, rd_byte};
            2'b01:   load_data = {{(DATA_WIDTH-16){rd_half[15] & ~unsigned_q}}, rd_half};
            default: load_data = i_memRdData;
        endcase
    end

    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d      = state_q;
        valid_d      = 1'b0;
        misaligned_d = 1'b0;
        bus_error_d  = 1'b0;
        result_d     = result_q;
        mem_req_d    = mem_req_q;
        wr_en_d      = wr_en_q;
        addr_d       = addr_q;
        be_d         = be_q;
        wr_data_d    = wr_data_q;
        size_d       = size_q;
        unsigned_d   = unsigned_q;
        lane_d       = lane_q;
        cnt_d        = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (i_valid) begin
                    if (!i_memRead && !i_memWrite) begin
                        valid_d  = 1'b1;
                        result_d = i_result;
                    end else if (illegal) begin
                        valid_d      = 1'b1;
                        misaligned_d = 1'b1;
                        result_d     = '0;
                    end else begin
                        state_d    = ST_ACCESS;
                        mem_req_d  = 1'b1;
                        wr_en_d    = i_memWrite;
                        addr_d     = {i_result[ADDR_WIDTH-1:2], 2'b00};
                        be_d       = be_calc;
                        wr_data_d  = wr_steer;
                        size_d     = i_access;
                        unsigned_d = i_unsigned;
                        lane_d     = i_result[1:0];
                        cnt_d      = '0;
                    end
                end
            end
            ST_ACCESS: begin
                if (i_memAck) begin
                    state_d   = ST_IDLE;
                    mem_req_d = 1'b0;
                    valid_d   = 1'b1;
                    result_d  = wr_en_q ? '0 : load_data;
                end else if (timeout_hit) begin
                    state_d     = ST_IDLE;
                    mem_req_d   = 1'b0;
                    valid_d     = 1'b1;
                    bus_error_d = 1'b1;
                    result_d    = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            state_q      <= ST_IDLE;
            valid_q      <= 1'b0;
            result_q     <= '0;
            misaligned_q <= 1'b0;
            bus_error_q  <= 1'b0;
            mem_req_q    <= 1'b0;
            wr_en_q      <= 1'b0;
            addr_q       <= '0;
            be_q         <= '0;
            wr_data_q    <= '0;
            size_q       <= '0;
            unsigned_q   <= 1'b0;
            lane_q       <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            valid_q      <= valid_d;
            result_q     <= result_d;
            misaligned_q <= misaligned_d;
            bus_error_q  <= bus_error_d;
            mem_req_q    <= mem_req_d;
            wr_en_q      <= wr_en_d;
            addr_q       <= addr_d;
            be_q         <= be_d;
            wr_data_q    <= wr_data_d;
            size_q       <= size_d;
            unsigned_q   <= unsigned_d;
            lane_q       <= lane_d;
            cnt_q        <= cnt_d;
        end
    end

    assign o_hazard        = (state_q == ST_ACCESS);
    assign o_valid         = valid_q;
    assign o_result        = result_q;
    assign o_misaligned    = misaligned_q;
    assign o_busError      = bus_error_q;
    assign o_memReq        = mem_req_q;
    assign o_memWrEnable   = wr_en_q;
    assign o_memAddr       = addr_q;
    assign o_memByteEnable = be_q;
    assign o_memWrData     = wr_data_q;

endmodule

// File: doc/stage_mem_access.md
Name: stage_mem_access

Overview:
Memory-access stage that consumes the execute stage's ALU result (address / pass-through value) and store operand (dataB), and sits between EX and writeback. Non-memory ops pass through with one register stage. Loads and stores run a request/acknowledge transaction on the data bus, with byte-lane steering, load sign/zero extension, misalignment detection and a bus timeout. Stalls upstream via o_hazard while a transaction is outstanding.

Parameters:
DATA_WIDTH, 32, data path width; fixed at 32 (four byte lanes).
ADDR_WIDTH, 32, data bus address width.
TIMEOUT_CYCLES, 16, cycles allowed without i_memAck before a bus error; 0 disables the timeout.

Ports:
i_clock  in  1  clock, rising edge.
i_reset  in  1  reset, synchronous, active-low.
i_valid  in  1  EX presents an instruction this cycle.
i_result  in  DATA_WIDTH  ALU result from EX; the address for memory ops, otherwise the value.
i_dataB  in  DATA_WIDTH  store data from EX.
i_memRead  in  1  instruction is a load.
i_memWrite  in  1  instruction is a store.
i_access  in  2  size: 00 byte, 01 half, 10 word, 11 illegal.
i_unsigned  in  1  load zero-extends (LBU/LHU).
o_hazard  out  1  stall request to upstream stages.
o_valid  out  1  o_result/status valid this cycle (single-cycle pulse per instruction).
o_result  out  DATA_WIDTH  load data or pass-through ALU result.
o_misaligned  out  1  access misaligned or illegal; qualified by o_valid.
o_busError  out  1  bus timeout; qualified by o_valid.
o_memReq  out  1  bus request.
o_memWrEnable  out  1  1 = write, 0 = read; qualified by o_memReq.
o_memAddr  out  ADDR_WIDTH  word-aligned address (addr[1:0] forced to 0).
o_memByteEnable  out  4  byte lanes.
o_memWrData  out  DATA_WIDTH  lane-steered store data.
i_memAck  in  1  bus completes transfer.
i_memRdData  in  DATA_WIDTH  read data; valid with i_memAck.

Behaviour:
- Reset (i_reset=0 at a rising edge):
  - state=IDLE; all outputs 0; the timeout counter clears.
  - A reset mid-transaction drops o_memReq at that edge; any later i_memAck is ignored.
- States: IDLE and ACCESS.
- IDLE, i_valid=1, neither memRead nor memWrite: next edge registers o_result=i_result, o_valid=1, flags 0. Latency 1.
- IDLE, i_valid=1, memory op:
  - Alignment check: half needs addr[0]=0; word needs addr[1:0]=0; i_access=11 is illegal; memRead and memWrite both set is illegal.
  - Illegal or misaligned: no bus cycle. Next edge gives o_valid=1, o_misaligned=1, o_result=0.
  - Otherwise the next edge enters ACCESS with o_memReq=1 and registers addr, byte enables, write data, size and sign control.
- Byte enables: byte gives 0001<<addr[1:0]; half gives 0011<<addr[1:0]; word gives 1111.
- Store data: byte is replicated into 4 lanes; half is replicated into 2 lanes; word is passed as-is.
- o_hazard=1 whenever state=ACCESS (combinational on state). Upstream holds its inputs; i_valid is ignored in ACCESS.
- ACCESS, i_memAck=1:
  - Next edge: o_memReq=0, state=IDLE, o_valid=1.
  - Load: the selected lane from i_memRdData is sign-extended (i_unsigned=0) or zero-extended.
  - Store: o_result=0.
  - A zero-wait ack (ack in the first ACCESS cycle) is legal; o_valid then comes 2 cycles after accept.
- Bus request outputs hold stable while o_memReq=1.
- Timeout: the counter increments each ACCESS cycle without ack. When the count reaches TIMEOUT_CYCLES, the next edge gives o_memReq=0, state=IDLE, o_valid=1, o_busError=1, o_result=0.
  - An ack arriving on that same cycle takes priority, giving a normal completion.
- i_memAck in IDLE is ignored.
- o_valid is high for exactly one cycle per accepted instruction. Flags are 0 whenever o_valid=0.

Test Plan:
- Pass-through: i_valid=1, no mem op, i_result=0x12345678 -> next cycle o_valid=1, o_result=0x12345678; o_memReq stays 0.
- Signed byte load: addr=0x1003, access=00, unsigned=0; ack 3 cycles after req with rdData=0x80FFFFFF -> o_memAddr=0x1000, BE=1000, o_hazard high 3 cycles, o_result=0xFFFFFF80; same with unsigned=1 -> 0x00000080.
- Half store: addr=0x2002, dataB=0xAAAABEEF, zero-wait ack -> BE=1100, wrData=0xBEEFBEEF, wrEnable=1, o_valid 2 cycles after accept, o_result=0.
- Misaligned: word load at addr=0x3001 -> no o_memReq; next cycle o_valid=1, o_misaligned=1; same for i_access=11.
- Timeout: TIMEOUT_CYCLES=4, load with no ack -> o_memReq drops after 4 request cycles, o_valid=1, o_busError=1; an ack on the 4th cycle gives normal completion instead.
- Reset mid-op: assert i_reset=0 during ACCESS -> next edge all outputs 0; a stray ack afterwards produces no o_valid.
